// File: rtl/glb_read.sv
// Stream sink: captures flush-armed 17-bit valid/ready tokens into a buffer and counts done tokens.
// Latency: capture on the accepting edge, done one cycle after the final done token, rd_data one cycle after rd_addr; backpressure: ready low outside RUN, when full, or on LFSR stall.
module glb_read #(
    parameter int          DEPTH       = 2048,
    parameter int          AW          = 11,
    parameter int          DONE_NUM    = 1,
    parameter logic [16:0] DONE_TOKEN  = 17'h10100,
    parameter int          STALL_EN    = 0,
    parameter int          STALL_SHIFT = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [16:0]   data,
    input  logic          valid,
    output logic          ready,
    input  logic          flush,
    output logic          done,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic [AW-1:0] rd_addr,
    output logic [16:0]   rd_data
);
    localparam int DW = $clog2(DONE_NUM + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           flush_q;
    logic [AW:0]    count_q, count_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [16:0]    rd_data_q;
    logic [16:0]    mem [DEPTH];
    logic           xfer;
    logic           rise, fall, full, stall;

    assign rise  = flush && !flush_q;
    assign fall  = !flush && flush_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign stall = (STALL_EN != 0) && (lfsr_q[STALL_SHIFT +: 2] == 2'b00);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dcnt_d  = dcnt_q;
        ovf_d   = ovf_q;
        lfsr_d  = lfsr_q;
        ready   = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            ST_IDLE:  if (rise) state_d = ST_ARMED;
            ST_ARMED: if (fall) state_d = ST_RUN;
            ST_RUN: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                ready  = !full && !stall;
                // A new flush edge aborts the capture; any token offered this cycle is dropped.
                if (rise) begin
                    state_d = ST_ARMED;
                end else begin
                    if (valid && ready) begin
                        xfer    = 1'b1;
                        count_d = count_q + 1'b1;
                        if (data == DONE_TOKEN) begin
                            dcnt_d = dcnt_q + 1'b1;
                            if (dcnt_d == DW'(DONE_NUM)) state_d = ST_DONE;
                        end
                    end
                    if (valid && full) ovf_d = 1'b1;
                end
            end
            ST_DONE:  if (rise) state_d = ST_ARMED;
            default:  state_d = ST_IDLE;
        endcase
        if (state_d == ST_ARMED) begin
            count_d = '0;
            dcnt_d  = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            flush_q   <= 1'b0;
            count_q   <= '0;
            dcnt_q    <= '0;
            ovf_q     <= 1'b0;
            lfsr_q    <= LFSR_SEED;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush;
            count_q   <= count_d;
            dcnt_q    <= dcnt_d;
            ovf_q     <= ovf_d;
            lfsr_q    <= lfsr_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) mem[count_q[AW-1:0]] <= data;
    end

    assign done     = (state_q == ST_DONE);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign rd_data  = rd_data_q;
endmodule

// File: tb/tb_glb_read.sv
// Directed bench for glb_read: four parameterisations share one stimulus bus; each task checks the relevant instance.
module tb_glb_read;
    logic        clk;
    logic        rst_n;
    logic [16:0] data;
    logic        valid;
    logic        flush;
    logic [10:0] rd_addr;

    logic        ready,   done,   overflow;
    logic [11:0] count;
    logic [16:0] rd_data;
    logic        ready_s, done_s, overflow_s;
    logic [11:0] count_s;
    logic [16:0] rd_data_s;
    logic        ready_m, done_m, overflow_m;
    logic [11:0] count_m;
    logic [16:0] rd_data_m;
    logic        ready_o, done_o, overflow_o;
    logic [2:0]  count_o;
    logic [16:0] rd_data_o;

    int total = 0;
    int bad   = 0;

    glb_read dut (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready), .flush(flush),
        .done(done), .count(count), .overflow(overflow), .rd_addr(rd_addr), .rd_data(rd_data)
    );
    glb_read #(.STALL_EN(1), .STALL_SHIFT(0), .LFSR_SEED(16'hACE1)) dut_s (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready_s), .flush(flush),
        .done(done_s), .count(count_s), .overflow(overflow_s), .rd_addr(rd_addr), .rd_data(rd_data_s)
    );
    glb_read #(.DONE_NUM(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready_m), .flush(flush),
        .done(done_m), .count(count_m), .overflow(overflow_m), .rd_addr(rd_addr), .rd_data(rd_data_m)
    );
    glb_read #(.DEPTH(4), .AW(2)) dut_o (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid), .ready(ready_o), .flush(flush),
        .done(done_o), .count(count_o), .overflow(overflow_o), .rd_addr(rd_addr[1:0]), .rd_data(rd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; data = '0; valid = 1'b0; flush = 1'b0; rd_addr = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Two-cycle flush pulse; returns with all instances in RUN.
    task automatic arm();
        flush = 1'b1;
        step();
        step();
        flush = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ready !== 1'b0)    begin bad++; $display("FAIL reset_ready got=%0h exp=0", ready); end
        total++; if (count !== 12'd0)   begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%0h exp=0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        total++; if (rd_data !== 17'h0) begin bad++; $display("FAIL reset_rd_data got=%0h exp=0", rd_data); end
    endtask

    task automatic test_basic();
        logic [16:0] toks [3];
        toks[0] = 17'h00005; toks[1] = 17'h00007; toks[2] = 17'h10100;
        do_reset();
        // Traffic before any flush must be ignored.
        data = 17'h00001; valid = 1'b1;
        step(); step(); step();
        total++; if (ready !== 1'b0)    begin bad++; $display("FAIL preflush_ready got=%0h exp=0", ready); end
        total++; if (count !== 12'd0)   begin bad++; $display("FAIL preflush_count got=%0d exp=0", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL preflush_overflow got=%0h exp=0", overflow); end
        arm();
        for (int i = 0; i < 3; i++) begin
            data = toks[i];
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL basic_ready[%0d] got=%0h exp=1", i, ready); end
            if (i == 2) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_early got=%0h exp=0", done); end
            end
            step();
        end
        valid = 1'b0;
        total++; if (done !== 1'b1)   begin bad++; $display("FAIL basic_done got=%0h exp=1", done); end
        total++; if (count !== 12'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", count); end
        total++; if (ready !== 1'b0)  begin bad++; $display("FAIL basic_ready_done got=%0h exp=0", ready); end
        for (int i = 0; i < 3; i++) begin
            rd_addr = 11'(i);
            step();
            total++; if (rd_data !== toks[i]) begin bad++; $display("FAIL basic_rd[%0d] got=%0h exp=%0h", i, rd_data, toks[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] m_lfsr;
        logic        exp_rdy;
        logic [16:0] tok;
        int          idx;
        int          cyc;
        do_reset();
        arm();
        m_lfsr = 16'hACE1;
        idx = 0;
        cyc = 0;
        while (idx < 64 && cyc < 1000) begin
            tok     = (idx == 63) ? 17'h10100 : 17'(32'h100 + idx);
            data    = tok;
            valid   = 1'b1;
            exp_rdy = (m_lfsr[1:0] != 2'b00);
            total++; if (ready_s !== exp_rdy) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0h exp=%0h", cyc, ready_s, exp_rdy); end
            step();
            if (exp_rdy) idx++;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            cyc++;
        end
        valid = 1'b0;
        total++; if (idx != 64) begin bad++; $display("FAIL bp_timeout sent=%0d exp=64", idx); end
        total++; if (done_s !== 1'b1)   begin bad++; $display("FAIL bp_done got=%0h exp=1", done_s); end
        total++; if (count_s !== 12'd64) begin bad++; $display("FAIL bp_count got=%0d exp=64", count_s); end
        for (int i = 0; i < 64; i++) begin
            rd_addr = 11'(i);
            step();
            tok = (i == 63) ? 17'h10100 : 17'(32'h100 + i);
            total++; if (rd_data_s !== tok) begin bad++; $display("FAIL bp_rd[%0d] got=%0h exp=%0h", i, rd_data_s, tok); end
        end
    endtask

    task automatic test_multi_done();
        logic [16:0] toks [4];
        toks[0] = 17'h00001; toks[1] = 17'h10100; toks[2] = 17'h00002; toks[3] = 17'h10100;
        do_reset();
        arm();
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data = toks[i];
            step();
            if (i < 3) begin
                total++; if (done_m !== 1'b0) begin bad++; $display("FAIL multi_done_early[%0d] got=%0h exp=0", i, done_m); end
            end
        end
        valid = 1'b0;
        total++; if (done_m !== 1'b1)   begin bad++; $display("FAIL multi_done got=%0h exp=1", done_m); end
        total++; if (count_m !== 12'd4) begin bad++; $display("FAIL multi_count got=%0d exp=4", count_m); end
    endtask

    task automatic test_overflow();
        do_reset();
        arm();
        valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = 17'(32'h11 + i);
            step();
            if (i == 3) begin
                total++; if (ready_o !== 1'b0)    begin bad++; $display("FAIL ovf_ready_full got=%0h exp=0", ready_o); end
                total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_early got=%0h exp=0", overflow_o); end
            end
        end
        valid = 1'b0;
        total++; if (count_o !== 3'd4)    begin bad++; $display("FAIL ovf_count got=%0d exp=4", count_o); end
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0h exp=1", overflow_o); end
        step(); step();
        total++; if (overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h exp=1", overflow_o); end
        for (int i = 0; i < 4; i++) begin
            rd_addr = 11'(i);
            step();
            total++; if (rd_data_o !== 17'(32'h11 + i)) begin bad++; $display("FAIL ovf_rd[%0d] got=%0h exp=%0h", i, rd_data_o, 17'(32'h11 + i)); end
        end
    endtask

    task automatic test_abort_rearm();
        do_reset();
        arm();
        valid = 1'b1;
        data = 17'h00021; step();
        data = 17'h00022; step();
        valid = 1'b0;
        total++; if (count !== 12'd2) begin bad++; $display("FAIL abort_pre_count got=%0d exp=2", count); end
        flush = 1'b1;
        step();
        total++; if (count !== 12'd0) begin bad++; $display("FAIL abort_count got=%0d exp=0", count); end
        total++; if (ready !== 1'b0)  begin bad++; $display("FAIL abort_ready got=%0h exp=0", ready); end
        flush = 1'b0;
        step();
        valid = 1'b1;
        data = 17'h00031; step();
        data = 17'h10100; step();
        valid = 1'b0;
        rd_addr = 11'd0;
        step();
        total++; if (rd_data !== 17'h00031) begin bad++; $display("FAIL rearm_rd0 got=%0h exp=31", rd_data); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL rearm_done got=%0h exp=1", done); end
        flush = 1'b1;
        step();
        total++; if (done !== 1'b0)   begin bad++; $display("FAIL done_rearm_done got=%0h exp=0", done); end
        total++; if (count !== 12'd0) begin bad++; $display("FAIL done_rearm_count got=%0d exp=0", count); end
        flush = 1'b0;
        step();
        valid = 1'b1;
        data = 17'h00041; step();
        valid = 1'b0;
        total++; if (count !== 12'd1) begin bad++; $display("FAIL run2_count got=%0d exp=1", count); end
        rst_n = 1'b0;
        step();
        total++; if (ready !== 1'b0)    begin bad++; $display("FAIL midrst_ready got=%0h exp=0", ready); end
        total++; if (count !== 12'd0)   begin bad++; $display("FAIL midrst_count got=%0d exp=0", count); end
        total++; if (done !== 1'b0)     begin bad++; $display("FAIL midrst_done got=%0h exp=0", done); end
        total++; if (overflow_o !== 1'b0) begin bad++; $display("FAIL midrst_overflow got=%0h exp=0", overflow_o); end
        total++; if (rd_data !== 17'h0) begin bad++; $display("FAIL midrst_rd_data got=%0h exp=0", rd_data); end
        rst_n = 1'b1;
        step();
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL postrst_idle_ready got=%0h exp=0", ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_multi_done();
        test_overflow();
        test_abort_rearm();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
